// File: rtl/sha1_round_sequencer_if.sv
// Block-level handshake and data bus of the SHA-1 round sequencer.
interface sha1_round_sequencer_if;
  logic         start;
  logic [511:0] block_in;
  logic [159:0] h_in;
  logic         ready;
  logic         done;
  logic [159:0] digest_out;

  modport master (output start, block_in, h_in, input ready, done, digest_out);
  modport slave  (input start, block_in, h_in, output ready, done, digest_out);
endinterface

// File: rtl/sha1_round_sequencer.sv
// Iterative SHA-1 compression: one round per cycle, 81 cycles from accept to done.
// Define SHA1_FINAL_ADD_EN to add the chaining value to the final working state.
module sha1_round_sequencer #(
  parameter bit USE_STD_IV = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  sha1_round_sequencer_if.slave  bus
);

  localparam logic [159:0] SHA1_IV =
    160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  state_t       state_q, state_d;
  logic [6:0]   t_q, t_d;
  logic         accept, finish;
  logic         done_q;
  logic [159:0] digest_q, digest_d;

  logic [31:0]  a_q, b_q, c_q, d_q, e_q;
  logic [31:0]  w_q [16];
  logic [31:0]  w_t, a_next;
  logic [159:0] h_init;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] f_fn(input logic [6:0] t, input logic [31:0] b,
                                       input logic [31:0] c, input logic [31:0] d);
    if (t < 7'd20)      return (b & c) | (~b & d);
    else if (t < 7'd40) return b ^ c ^ d;
    else if (t < 7'd60) return (b & c) | (b & d) | (c & d);
    else                return b ^ c ^ d;
  endfunction

  function automatic logic [31:0] k_fn(input logic [6:0] t);
    if (t < 7'd20)      return 32'h5A827999;
    else if (t < 7'd40) return 32'h6ED9EBA1;
    else if (t < 7'd60) return 32'h8F1BBCDC;
    else                return 32'hCA62C1D6;
  endfunction

  assign h_init = USE_STD_IV ? SHA1_IV : bus.h_in;

  // The first 16 rounds recycle the block words, leaving W0..W15 in place for expansion.
  assign w_t    = (t_q < 7'd16) ? w_q[0]
                                : rotl(w_q[13] ^ w_q[8] ^ w_q[2] ^ w_q[0], 1);
  assign a_next = f_fn(t_q, b_q, c_q, d_q) + rotl(a_q, 5) + e_q + k_fn(t_q) + w_t;

`ifdef SHA1_FINAL_ADD_EN
  logic [31:0] h0_q, h1_q, h2_q, h3_q, h4_q;
  assign digest_d = {h0_q + a_q, h1_q + b_q, h2_q + c_q, h3_q + d_q, h4_q + e_q};

  always_ff @(posedge clk) begin
    if (accept) {h0_q, h1_q, h2_q, h3_q, h4_q} <= h_init;
  end
`else
  assign digest_d = {a_q, b_q, c_q, d_q, e_q};
`endif

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          t_d     = 7'd0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (t_q == 7'd79) begin
          t_d     = 7'd0;
          state_d = FINAL;
        end else begin
          t_d = t_q + 7'd1;
        end
      end
      FINAL: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      t_q      <= 7'd0;
      done_q   <= 1'b0;
      digest_q <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      done_q  <= finish;
      if (finish) digest_q <= digest_d;
    end
  end

  // Working state and message window carry no reset; they are always loaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      {a_q, b_q, c_q, d_q, e_q} <= h_init;
      for (int i = 0; i < 16; i++) w_q[i] <= bus.block_in[511 - 32*i -: 32];
    end else if (state_q == ROUND) begin
      a_q <= a_next;
      b_q <= a_q;
      c_q <= rotl(b_q, 30);
      d_q <= c_q;
      e_q <= d_q;
      for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
      w_q[15] <= w_t;
    end
  end

  assign bus.ready      = (state_q == IDLE);
  assign bus.done       = done_q;
  assign bus.digest_out = digest_q;

endmodule

// File: tb/tb_sha1_round_sequencer.sv
// Randomised bench for sha1_round_sequencer against a whole-block SHA-1 reference model.
module tb_sha1_round_sequencer;

  localparam logic [159:0] IV      = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMP_BLK = {32'h80000000, 480'h0};
  localparam logic [159:0] ABC_DIG = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] EMP_DIG = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha1_round_sequencer_if bus1 ();
  sha1_round_sequencer_if bus2 ();

  assign bus2.start    = bus1.start;
  assign bus2.block_in = bus1.block_in;
  assign bus2.h_in     = bus1.h_in;

  sha1_round_sequencer #(.USE_STD_IV(1'b0)) dut    (.clk(clk), .rst(rst), .bus(bus1.slave));
  sha1_round_sequencer #(.USE_STD_IV(1'b1)) dut_iv (.clk(clk), .rst(rst), .bus(bus2.slave));

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Straight textbook SHA-1 compression of one block.
  function automatic logic [159:0] sha1_ref(input logic [159:0] h, input logic [511:0] blk);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    logic [31:0] hw [5];
    for (int i = 0; i < 5; i++) hw[i] = h[159 - 32*i -: 32];
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 80; t++) w[t] = rl(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
    a = hw[0]; b = hw[1]; c = hw[2]; d = hw[3]; e = hw[4];
    for (int t = 0; t < 80; t++) begin
      if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      tmp = rl(a, 5) + f + e + k + w[t];
      e = d; d = c; c = rl(b, 30); b = a; a = tmp;
    end
`ifdef SHA1_FINAL_ADD_EN
    return {hw[0] + a, hw[1] + b, hw[2] + c, hw[3] + d, hw[4] + e};
`else
    return {a, b, c, d, e};
`endif
  endfunction

  // Published digests include the feed-forward add; without it the IV is removed word-wise.
  function automatic logic [159:0] adj(input logic [159:0] lit);
    logic [159:0] iv_v, r;
    iv_v = IV;
    r    = lit;
`ifndef SHA1_FINAL_ADD_EN
    for (int i = 0; i < 5; i++) r[159 - 32*i -: 32] = lit[159 - 32*i -: 32] - iv_v[159 - 32*i -: 32];
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: busy countdown of 81 edges per accepted block.
  int           m_cnt = 0;
  logic         m_done = 1'b0;
  logic [159:0] m_dig1 = '0, m_dig2 = '0, pend1 = '0, pend2 = '0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_dig1 <= '0;
      m_dig2 <= '0;
      chk_en <= 1'b1;
    end else begin
      m_done <= 1'b0;
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_dig1 <= pend1;
          m_dig2 <= pend2;
        end
      end else if (bus1.start) begin
        pend1 <= sha1_ref(bus1.h_in, bus1.block_in);
        pend2 <= sha1_ref(IV, bus1.block_in);
        m_cnt <= 81;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready",     bus1.ready,      (m_cnt == 0));
      check("done",      bus1.done,       m_done);
      check("digest",    bus1.digest_out, m_dig1);
      check("iv_ready",  bus2.ready,      (m_cnt == 0));
      check("iv_done",   bus2.done,       m_done);
      check("iv_digest", bus2.digest_out, m_dig2);
    end
  end

  task automatic do_start(input logic [511:0] blk);
    bus1.block_in = blk;
    bus1.start    = 1'b1;
    @(posedge clk);
    #1 bus1.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1 lat++;
      if (bus1.done) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL done_timeout: no done within %0d cycles", lat);
  endtask

  initial begin
    int           lat, ndone;
    logic [511:0] blk0;
    logic [159:0] dig0;

    bus1.start    = 1'b0;
    bus1.block_in = '0;
    bus1.h_in     = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready",  bus1.ready,      1'b1);
    check("rst_done",   bus1.done,       1'b0);
    check("rst_digest", bus1.digest_out, '0);

    // "abc" with the IV on h_in
    bus1.h_in = IV;
    do_start(ABC_BLK);
    wait_done(lat);
    check("abc_latency", lat, 81);
    check("abc_digest",  bus1.digest_out, adj(ABC_DIG));
    check("abc_iv_dut",  bus2.digest_out, adj(ABC_DIG));

    // empty message, then "abc" accepted in the done cycle
    repeat (2) @(posedge clk);
    #1 do_start(EMP_BLK);
    wait_done(lat);
    check("empty_digest", bus1.digest_out, adj(EMP_DIG));
    do_start(ABC_BLK);
    wait_done(lat);
    check("b2b_latency", lat, 81);
    check("b2b_abc",     bus1.digest_out, adj(ABC_DIG));

    // start held high, block toggling while busy
    repeat (3) @(posedge clk);
    #1 blk0 = {16{$urandom()}};
    bus1.block_in = blk0;
    bus1.start    = 1'b1;
    @(posedge clk);
    #1 ndone = 0;
    dig0 = '0;
    for (int i = 0; i < 84; i++) begin
      bus1.block_in = {16{$urandom()}};
      @(posedge clk);
      #1 if (bus1.done) begin
        ndone++;
        dig0 = bus1.digest_out;
      end
    end
    bus1.start = 1'b0;
    check("hold_one_done", ndone, 1);
    check("hold_digest",   dig0, sha1_ref(IV, blk0));
    repeat (90) @(posedge clk);

    // reset at E40 discards the hash
    #1 do_start(ABC_BLK);
    repeat (39) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_ready",  bus1.ready,      1'b1);
    check("midrst_done",   bus1.done,       1'b0);
    check("midrst_digest", bus1.digest_out, '0);
    repeat (100) @(posedge clk);

    // fresh "abc"; h_in random so only the fixed-IV instance sees the IV
    #1 bus1.h_in = {5{$urandom()}};
    do_start(ABC_BLK);
    wait_done(lat);
    check("post_rst_abc_iv", bus2.digest_out, adj(ABC_DIG));

    // random blocks and chaining values
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1 bus1.h_in = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      for (int i = 0; i < 16; i++) blk0[511 - 32*i -: 32] = $urandom();
      do_start(blk0);
      bus1.h_in     = {5{$urandom()}};
      bus1.block_in = {16{$urandom()}};
      wait_done(lat);
    end
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
